// File: rtl/matrix_transpose_stream.sv
// Element-serial square matrix transposer: row-major words in, column-major words out.
// Two ping-pong banks let one matrix be written while the previous one is read.
module matrix_transpose_stream #(
  parameter int MATRIX_SIZE = 3,
  parameter int WORD_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WORD_LENGTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_first,
  output logic                   out_last
);

  localparam int CW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(MATRIX_SIZE - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [WORD_LENGTH-1:0] mem [2][MATRIX_SIZE][MATRIX_SIZE];
  logic [1:0]    bank_full;
  logic          wr_bank, rd_bank;
  logic [CW-1:0] wr_row, wr_col, rd_row, rd_col;
  logic          wr_fire, rd_fire, wr_end, rd_end;

  assign in_ready  = !bank_full[wr_bank];
  assign out_valid = bank_full[rd_bank];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_end    = (wr_row == LAST_IDX) && (wr_col == LAST_IDX);
  assign rd_end    = (rd_row == LAST_IDX) && (rd_col == LAST_IDX);

  assign out_data  = out_valid ? mem[rd_bank][rd_row][rd_col] : '0;
  assign out_first = out_valid && (rd_row == '0) && (rd_col == '0);
  assign out_last  = out_valid && rd_end;

  // Storage is deliberately left uncleared by reset; the bank flags gate all reads.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_row][wr_col] <= in_data;
  end

  // Row-major write walk.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank <= 1'b0;
      wr_row  <= '0;
      wr_col  <= '0;
    end else if (wr_fire) begin
      if (wr_col == LAST_IDX) begin
        wr_col <= '0;
        if (wr_row == LAST_IDX) begin
          wr_row  <= '0;
          wr_bank <= !wr_bank;
        end else begin
          wr_row <= wr_row + ONE;
        end
      end else begin
        wr_col <= wr_col + ONE;
      end
    end
  end

  // Column-major read walk: row index moves fastest.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_bank <= 1'b0;
      rd_row  <= '0;
      rd_col  <= '0;
    end else if (rd_fire) begin
      if (rd_row == LAST_IDX) begin
        rd_row <= '0;
        if (rd_col == LAST_IDX) begin
          rd_col  <= '0;
          rd_bank <= !rd_bank;
        end else begin
          rd_col <= rd_col + ONE;
        end
      end else begin
        rd_row <= rd_row + ONE;
      end
    end
  end

  // Fill and drain always target different banks, so both updates may land together.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_full <= 2'b00;
    end else begin
      if (wr_fire && wr_end) bank_full[wr_bank] <= 1'b1;
      if (rd_fire && rd_end) bank_full[rd_bank] <= 1'b0;
    end
  end

endmodule
